// File: rtl/clock_switch_ctrl.sv
// rtl/clock_switch_ctrl.sv - sequences the glitch-free clock mux select for two requesters
//
// Purpose: arbitrates round-robin between two source requests and drives the
// clock mux select. After every change of sel_out the winning requester is
// held off for SETTLE_CYCLES, then acked. A DWELL_CYCLES hold-off follows
// before the next grant. Runs on the always-on system clock.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   req0_valid/sel/ack        requester 0 handshake (ack is a one-cycle pulse)
//   req1_valid/sel/ack        requester 1 handshake
//   lock                      blocks new grants while high (sampled in IDLE)
//   sel_out                   registered mux select
//   busy                      high in SWITCH and DWELL
//   switch_count              completed source changes, saturating at 255
module clock_switch_ctrl #(
  parameter bit RESET_SEL     = 1'b0,
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_sel,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic       req1_sel,
  output logic       req1_ack,
  input  logic       lock,
  output logic       sel_out,
  output logic       busy,
  output logic [7:0] switch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    DWELL  = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DWELL_LOAD  = (DWELL_CYCLES == 0) ? 8'd0 : 8'(DWELL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sw_cnt_q, sw_cnt_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       last_q, last_d;   // index granted most recently
  logic       gnt_q, gnt_d;     // index owning the in-flight switch

  logic v0, v1, gidx, gsel, owner_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sw_cnt_d = sw_cnt_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    last_d   = last_q;
    gnt_d    = gnt_q;

    // A requester still holding valid during its own ack cycle has not yet
    // seen the ack, so it is not a new request until the following cycle.
    v0          = req0_valid & ~ack0_q;
    v1          = req1_valid & ~ack1_q;
    gidx        = (v0 && v1) ? ~last_q : v1;
    gsel        = gidx ? req1_sel : req0_sel;
    owner_valid = gnt_q ? req1_valid : req0_valid;

    case (state_q)
      IDLE: begin
        if (!lock && (v0 || v1)) begin
          last_d = gidx;
          if (gsel == sel_q) begin
            ack0_d = ~gidx;
            ack1_d = gidx;
          end else begin
            sel_d   = gsel;
            state_d = SWITCH;
            busy_d  = 1'b1;
            cnt_d   = SETTLE_LOAD;
            gnt_d   = gidx;
          end
        end
      end
      SWITCH: begin
        if (cnt_q == 8'd0) begin
          // A withdrawn owner still completes the switch, just without ack.
          if (owner_valid) begin
            ack0_d = ~gnt_q;
            ack1_d = gnt_q;
          end
          if (sw_cnt_q != 8'hFF) sw_cnt_d = sw_cnt_q + 8'd1;
          if (DWELL_CYCLES == 0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DWELL;
            cnt_d   = DWELL_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DWELL: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      sw_cnt_q <= 8'd0;
      sel_q    <= RESET_SEL;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      last_q   <= 1'b1;   // requester 0 wins the first tie
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_cnt_q <= sw_cnt_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
    end
  end

  assign req0_ack     = ack0_q;
  assign req1_ack     = ack1_q;
  assign sel_out      = sel_q;
  assign busy         = busy_q;
  assign switch_count = sw_cnt_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// tb/tb_clock_switch_ctrl.sv - self-checking bench for clock_switch_ctrl
module tb_clock_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_sel, req1_valid, req1_sel, lock;
  logic       req0_ack, req1_ack, sel_out, busy;
  logic [7:0] switch_count;

  int n_total = 0;
  int n_pass  = 0;

  clock_switch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_sel     (req0_sel),
    .req0_ack     (req0_ack),
    .req1_valid   (req1_valid),
    .req1_sel     (req1_sel),
    .req1_ack     (req1_ack),
    .lock         (lock),
    .sel_out      (sel_out),
    .busy         (busy),
    .switch_count (switch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, v0, s0, v1, s1, lk;
    logic ack0, ack1, sel, bsy;
    int   cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req0_sel = 1'b0;
    req1_valid = 1'b0; req1_sel = 1'b0; lock = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int a0, input int a1,
                         input int s, input int b, input int c);
    chk({tag, " ack0"}, int'(req0_ack), a0);
    chk({tag, " ack1"}, int'(req1_ack), a1);
    chk({tag, " sel"},  int'(sel_out),  s);
    chk({tag, " busy"}, int'(busy),     b);
    chk({tag, " count"}, int'(switch_count), c);
  endtask

  initial begin
    //           rst v0 s0 v1 s1 lk   a0 a1 sel bsy cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

    do_reset();

    // Same-source acks, ack-cycle masking, lock in IDLE.
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; req0_valid = vecs[i].v0; req0_sel = vecs[i].s0;
      req1_valid = vecs[i].v1; req1_sel = vecs[i].s1; lock = vecs[i].lk;
      step();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].ack0), int'(vecs[i].ack1),
              int'(vecs[i].sel), int'(vecs[i].bsy), vecs[i].cnt);
    end

    // Tie after reset: req0 switch first, req1 granted right after DWELL.
    do_reset();
    req0_valid = 1; req0_sel = 1; req1_valid = 1; req1_sel = 0;
    for (int k = 1; k <= 50; k++) begin
      step();
      chk_all($sformatf("tie k%0d", k), int'(k == 9), int'(k == 34),
              (k <= 25) ? 1 : 0, int'((k <= 24) || (k >= 26 && k <= 49)),
              int'(k >= 9) + int'(k >= 34));
      if (req0_ack) req0_valid = 0;
      if (req1_ack) req1_valid = 0;
    end

    // Round-robin pointer: last grant was req1, so req0 wins this tie.
    req0_valid = 1; req0_sel = 0; req1_valid = 1; req1_sel = 0;
    step();
    chk_all("rr first", 1, 0, 0, 0, 2);
    req0_valid = 0;
    step();
    chk_all("rr second", 0, 1, 0, 0, 2);
    req1_valid = 0;
    step();
    chk_all("rr idle", 0, 0, 0, 0, 2);

    // lock holds a pending request; lock during SWITCH changes nothing.
    do_reset();
    lock = 1; req1_valid = 1; req1_sel = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("lock sel", int'(sel_out), 0);
      chk("lock ack1", int'(req1_ack), 0);
    end
    lock = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 2) lock = 1;
      chk_all($sformatf("unlock k%0d", k), 0, int'(k == 9), 1,
              int'(k <= 24), int'(k >= 9));
      if (req1_ack) req1_valid = 0;
    end
    lock = 0;

    // Withdrawal during SWITCH: no ack, count still bumps, DWELL enforced.
    do_reset();
    req0_valid = 1; req0_sel = 1;
    for (int k = 1; k <= 26; k++) begin
      step();
      if (k == 4) begin
        req0_valid = 0; req1_valid = 1; req1_sel = 0;
      end
      chk_all($sformatf("wd k%0d", k), 0, 0, (k <= 25) ? 1 : 0,
              int'((k <= 24) || (k == 26)), int'(k >= 9));
    end

    // Reset in the middle of SWITCH, then a normal request.
    do_reset();
    req0_valid = 1; req0_sel = 1;
    for (int k = 1; k <= 5; k++) step();
    chk("mid sel", int'(sel_out), 1);
    rst = 1;
    step();
    rst = 0;
    chk_all("abort", 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_all($sformatf("post k%0d", k), int'(k == 9), 0, 1, 1, int'(k == 9));
    end
    req0_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
